// File: rtl/fifo_controller_if.sv
// fifo_controller_if
//   Bundles the controller's request/status handshake and every datapath
//   control line into one connection.
//
//   Requests from the user side and flags from the datapath:
//     WriteReq, ReadReq, FlushReq   level requests, held until answered
//     full, empty                   registered status-register flags
//   Controls and status driven by the controller:
//     ClearReadBuff, ClearWriteBuff, ClearFIFO, ClearPoint, ClearStaReg
//     LoadReadBuff, LoadWriteBuff, ChipEnable, OutEnable, Write, sel, EnableP
//     WrAck, WrDone, WrErr, RdDone, RdErr, FlushDone, Busy
//
//   master: the environment (requester plus datapath)
//   slave:  the controller
interface fifo_controller_if;
    logic WriteReq;
    logic ReadReq;
    logic FlushReq;
    logic full;
    logic empty;

    logic ClearReadBuff;
    logic ClearWriteBuff;
    logic ClearFIFO;
    logic ClearPoint;
    logic ClearStaReg;
    logic LoadReadBuff;
    logic LoadWriteBuff;
    logic ChipEnable;
    logic OutEnable;
    logic Write;
    logic sel;
    logic EnableP;

    logic WrAck;
    logic WrDone;
    logic WrErr;
    logic RdDone;
    logic RdErr;
    logic FlushDone;
    logic Busy;

    modport master (
        output WriteReq, ReadReq, FlushReq, full, empty,
        input  ClearReadBuff, ClearWriteBuff, ClearFIFO, ClearPoint, ClearStaReg,
        input  LoadReadBuff, LoadWriteBuff, ChipEnable, OutEnable, Write, sel, EnableP,
        input  WrAck, WrDone, WrErr, RdDone, RdErr, FlushDone, Busy
    );

    modport slave (
        input  WriteReq, ReadReq, FlushReq, full, empty,
        output ClearReadBuff, ClearWriteBuff, ClearFIFO, ClearPoint, ClearStaReg,
        output LoadReadBuff, LoadWriteBuff, ChipEnable, OutEnable, Write, sel, EnableP,
        output WrAck, WrDone, WrErr, RdDone, RdErr, FlushDone, Busy
    );
endinterface

// File: rtl/fifo_controller.sv
// fifo_controller
//   Sequencing FSM for the FIFO datapath. Turns level write/read/flush
//   requests into ordered buffer, RAM and pointer controls, arbitrates
//   between simultaneous requests (flush first, then round-robin between
//   eligible write and read), and reports acknowledge/done/error pulses.
//
//   Ports:
//     clk    rising-edge clock
//     Clear  asynchronous active-high reset
//     ctrl   fifo_controller_if.slave: requests, full/empty flags in;
//            datapath controls and status pulses out
//
//   All outputs are decoded from registered state only; the two error
//   pulses are registered one cycle after the IDLE cycle that sampled them.
module fifo_controller #(
    parameter int CLEAR_CYCLES  = 2,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic              clk,
    input  logic              Clear,
    fifo_controller_if.slave  ctrl
);

    typedef enum logic [3:0] {
        INIT, IDLE, WR_LOAD, WR_MEM, WR_PTR, RD_MEM, RD_LOAD, RD_PTR, FLUSH, SETTLE
    } stateT;

    typedef enum logic [1:0] {
        OP_WRITE, OP_READ, OP_FLUSH
    } opT;

    localparam logic [3:0] CLEAR_LAST  = 4'(CLEAR_CYCLES - 1);
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    stateT       state, nextState;
    logic [3:0]  cycleCount, nextCount;
    logic        lastOpWrite, nextLastOpWrite;
    opT          settleOp, nextSettleOp;
    logic        wrErrReg, rdErrReg;
    logic        wrErrNext, rdErrNext;
    logic        writeOk, readOk;

    // State, shared INIT/SETTLE cycle counter, round-robin history, the
    // operation being finished in SETTLE and the registered error pulses.
    // lastOpWrite resets to 0 (read) so the first contested grant is a write.
    always_ff @(posedge clk or posedge Clear) begin
        if (Clear) begin
            state       <= INIT;
            cycleCount  <= 4'd0;
            lastOpWrite <= 1'b0;
            settleOp    <= OP_FLUSH;
            wrErrReg    <= 1'b0;
            rdErrReg    <= 1'b0;
        end else begin
            state       <= nextState;
            cycleCount  <= nextCount;
            lastOpWrite <= nextLastOpWrite;
            settleOp    <= nextSettleOp;
            wrErrReg    <= wrErrNext;
            rdErrReg    <= rdErrNext;
        end
    end

    // Next-state logic. The counter is held at zero outside INIT/SETTLE so
    // each counted phase starts from zero. Requests and flags only matter in
    // IDLE; a rejected request is flagged every IDLE cycle it stays asserted.
    always_comb begin
        nextState       = state;
        nextCount       = 4'd0;
        nextLastOpWrite = lastOpWrite;
        nextSettleOp    = settleOp;
        wrErrNext       = 1'b0;
        rdErrNext       = 1'b0;
        writeOk         = ctrl.WriteReq && !ctrl.full;
        readOk          = ctrl.ReadReq && !ctrl.empty;

        case (state)
            INIT: begin
                if (cycleCount == CLEAR_LAST) begin
                    nextState = IDLE;
                end else begin
                    nextCount = cycleCount + 4'd1;
                end
            end
            IDLE: begin
                wrErrNext = ctrl.WriteReq && ctrl.full;
                rdErrNext = ctrl.ReadReq && ctrl.empty;
                if (ctrl.FlushReq) begin
                    nextState = FLUSH;
                end else if (writeOk && readOk) begin
                    nextState = lastOpWrite ? RD_MEM : WR_LOAD;
                end else if (writeOk) begin
                    nextState = WR_LOAD;
                end else if (readOk) begin
                    nextState = RD_MEM;
                end
            end
            WR_LOAD: nextState = WR_MEM;
            WR_MEM:  nextState = WR_PTR;
            WR_PTR: begin
                nextState       = SETTLE;
                nextSettleOp    = OP_WRITE;
                nextLastOpWrite = 1'b1;
            end
            RD_MEM:  nextState = RD_LOAD;
            RD_LOAD: nextState = RD_PTR;
            RD_PTR: begin
                nextState       = SETTLE;
                nextSettleOp    = OP_READ;
                nextLastOpWrite = 1'b0;
            end
            FLUSH: begin
                nextState    = SETTLE;
                nextSettleOp = OP_FLUSH;
            end
            SETTLE: begin
                if (cycleCount == SETTLE_LAST) begin
                    nextState = IDLE;
                end else begin
                    nextCount = cycleCount + 4'd1;
                end
            end
            default: nextState = INIT;
        endcase
    end

    // Moore output decode. Flush deliberately leaves ClearFIFO low so RAM
    // contents survive; only pointers, status and buffers are cleared.
    always_comb begin
        ctrl.ClearReadBuff  = 1'b0;
        ctrl.ClearWriteBuff = 1'b0;
        ctrl.ClearFIFO      = 1'b0;
        ctrl.ClearPoint     = 1'b0;
        ctrl.ClearStaReg    = 1'b0;
        ctrl.LoadReadBuff   = 1'b0;
        ctrl.LoadWriteBuff  = 1'b0;
        ctrl.ChipEnable     = 1'b0;
        ctrl.OutEnable      = 1'b0;
        ctrl.Write          = 1'b0;
        ctrl.sel            = 1'b0;
        ctrl.EnableP        = 1'b0;
        ctrl.WrAck          = 1'b0;
        ctrl.WrDone         = 1'b0;
        ctrl.RdDone         = 1'b0;
        ctrl.FlushDone      = 1'b0;
        ctrl.WrErr          = wrErrReg;
        ctrl.RdErr          = rdErrReg;
        ctrl.Busy           = (state != IDLE);

        case (state)
            INIT: begin
                ctrl.ClearReadBuff  = 1'b1;
                ctrl.ClearWriteBuff = 1'b1;
                ctrl.ClearFIFO      = 1'b1;
                ctrl.ClearPoint     = 1'b1;
                ctrl.ClearStaReg    = 1'b1;
            end
            WR_LOAD: begin
                ctrl.LoadWriteBuff = 1'b1;
                ctrl.WrAck         = 1'b1;
            end
            WR_MEM: begin
                ctrl.ChipEnable = 1'b1;
                ctrl.Write      = 1'b1;
                ctrl.sel        = 1'b1;
            end
            WR_PTR: begin
                ctrl.EnableP = 1'b1;
                ctrl.sel     = 1'b1;
            end
            RD_MEM: begin
                ctrl.ChipEnable = 1'b1;
                ctrl.OutEnable  = 1'b1;
            end
            RD_LOAD: begin
                ctrl.ChipEnable   = 1'b1;
                ctrl.OutEnable    = 1'b1;
                ctrl.LoadReadBuff = 1'b1;
            end
            RD_PTR: begin
                ctrl.EnableP = 1'b1;
            end
            FLUSH: begin
                ctrl.ClearReadBuff  = 1'b1;
                ctrl.ClearWriteBuff = 1'b1;
                ctrl.ClearPoint     = 1'b1;
                ctrl.ClearStaReg    = 1'b1;
            end
            SETTLE: begin
                if (cycleCount == SETTLE_LAST) begin
                    ctrl.WrDone    = (settleOp == OP_WRITE);
                    ctrl.RdDone    = (settleOp == OP_READ);
                    ctrl.FlushDone = (settleOp == OP_FLUSH);
                end
            end
            default: ;
        endcase
    end

endmodule
